sbox_config_loader: RTL and testbench

- Configuration writer for a column of switch_box_element_two-style switch boxes.
- Accepts a configuration stream as WORD_W-bit words over a valid/ready handshake and assembles it in a shadow register.
- Drives all NUM_SB 16-bit select vectors from one register, updated atomically only after the full stream arrives. Routing muxes never see a partial configuration.
- Sits between the chip config port/scan controller and the switch-box array.

---
 rtl/sbox_config_loader.sv | 115 +++++++++++
 tb/tb_sbox_config_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sbox_config_loader.sv
// Switch-box column config loader: assembles a word stream in a shadow
// register and commits all select vectors atomically once it is complete.
module sbox_config_loader #(
  parameter int NUM_SB = 4,
  parameter int CFG_W  = 16,
  parameter int WORD_W = 8
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic                                        abort,
  input  logic [WORD_W-1:0]                           in_data,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  output logic [NUM_SB*CFG_W-1:0]                     cfg_out,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        err,
  output logic [$clog2(NUM_SB*CFG_W/WORD_W+1)-1:0]    word_cnt
);

  localparam int TOT_W  = NUM_SB * CFG_W;
  localparam int NWORDS = TOT_W / WORD_W;
  localparam int CNT_W  = $clog2(NWORDS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [TOT_W-1:0]   r_shadow;
  logic [TOT_W-1:0]   r_cfg;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done;
  logic               r_err;

  logic               w_wr;
  logic               w_cnt_clr;
  logic               w_commit;
  logic               w_done_nxt;
  logic               w_err_nxt;

  // Next-state and control decode; abort wins over a coincident last word
  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_cnt_clr   = 1'b0;
    w_commit    = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOAD;
          w_cnt_clr   = 1'b1;
        end
      end
      S_LOAD: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_cnt_clr   = 1'b1;
          w_err_nxt   = 1'b1;
        end else if (in_valid) begin
          w_wr = 1'b1;
          if (r_cnt == LAST)
            w_state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        w_commit    = 1'b1;
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counter, shadow assembly and atomic commit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_shadow <= '0;
      r_cfg    <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      if (w_cnt_clr)
        r_cnt <= '0;
      else if (w_wr)
        r_cnt <= r_cnt + 1'b1;
      for (int i = 0; i < NWORDS; i++) begin
        if (w_wr && (r_cnt == i[CNT_W-1:0]))
          r_shadow[i*WORD_W +: WORD_W] <= in_data;
      end
      if (w_commit)
        r_cfg <= r_shadow;
    end
  end

  assign in_ready = (r_state == S_LOAD);
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign err      = r_err;
  assign cfg_out  = r_cfg;
  assign word_cnt = r_cnt;

endmodule

// File: tb/tb_sbox_config_loader.sv
// Directed bench for sbox_config_loader: load, stall, abort, ignored
// inputs, mid-load reset and back-to-back loads.
module tb_sbox_config_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] cfg_out;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  word_cnt;

  int total;
  int bad;

  sbox_config_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .cfg_out  (cfg_out),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .word_cnt (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  logic [63:0] v_seq;
  logic [63:0] v_mix;

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b1;
    v_seq    = 64'h0807060504030201;
    v_mix    = 64'hFFFF00005555AAAA;
    step();
    step();
    chk("rst_cfg", cfg_out, 64'h0);
    chk("rst_rdy", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_cnt", word_cnt, 4'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    step();

    // full load 01..08
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("full_rdy", in_ready, 1'b1);
      put(v_seq[i*8 +: 8]);
    end
    chk("commit_cfg_old", cfg_out, 64'h0);
    chk("commit_busy", busy, 1'b1);
    chk("commit_rdy", in_ready, 1'b0);
    chk("commit_cnt", word_cnt, 4'd8);
    step();
    chk("full_cfg", cfg_out, v_seq);
    chk("full_done", done, 1'b1);
    chk("full_busy", busy, 1'b0);
    step();
    chk("done_pulse", done, 1'b0);

    // ignored inputs in IDLE
    in_valid = 1'b1;
    in_data  = 8'h5A;
    abort    = 1'b1;
    step();
    step();
    chk("idle_busy", busy, 1'b0);
    chk("idle_err", err, 1'b0);
    chk("idle_cnt", word_cnt, 4'd8);
    chk("idle_rdy", in_ready, 1'b0);
    chk("idle_cfg", cfg_out, v_seq);
    in_valid = 1'b0;
    abort    = 1'b0;

    // abort after 5 handshakes
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) put(8'hAA);
    chk("ab5_cnt", word_cnt, 4'd5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab5_err", err, 1'b1);
    chk("ab5_busy", busy, 1'b0);
    chk("ab5_cnt0", word_cnt, 4'd0);
    chk("ab5_cfg", cfg_out, v_seq);
    step();
    chk("ab5_errpulse", err, 1'b0);
    chk("ab5_nodone", done, 1'b0);

    // abort together with 8th word
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) put(8'hAA);
    abort = 1'b1;
    put(8'hAA);
    abort = 1'b0;
    chk("ab8_err", err, 1'b1);
    chk("ab8_done", done, 1'b0);
    chk("ab8_busy", busy, 1'b0);
    step();
    chk("ab8_done2", done, 1'b0);
    chk("ab8_cfg", cfg_out, v_seq);

    // mid-load reset
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) put(8'h33);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_cfg", cfg_out, 64'h0);
    chk("mrst_cnt", word_cnt, 4'd0);
    chk("mrst_busy", busy, 1'b0);

    // full load of mixed pattern
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) put(v_mix[i*8 +: 8]);
    step();
    chk("mix_cfg", cfg_out, v_mix);
    chk("mix_el0", cfg_out[15:0], 16'hAAAA);
    chk("mix_el3", cfg_out[63:48], 16'hFFFF);
    chk("mix_done", done, 1'b1);

    // back-to-back start in done cycle, then stalled load
    start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_cnt", word_cnt, 4'd0);
    for (int i = 0; i < 4; i++) put(v_seq[i*8 +: 8]);
    for (int i = 0; i < 3; i++) begin
      start = (i == 1);
      step();
      chk("stall_cnt", word_cnt, 4'd4);
      chk("stall_cfg", cfg_out, v_mix);
      chk("stall_busy", busy, 1'b1);
    end
    start = 1'b0;
    for (int i = 4; i < 8; i++) put(v_seq[i*8 +: 8]);
    chk("stall_pre", cfg_out, v_mix);
    step();
    chk("stall_cfg_fin", cfg_out, v_seq);
    chk("stall_done", done, 1'b1);
    chk("stall_err", err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
